// File: rtl/hadd_mask_pkg.sv
// Shared constants and the single-step PRNG function for the half-adder
// masking front end.
package hadd_mask_pkg;

  localparam int unsigned LFSR_W = 16;
  localparam logic [LFSR_W-1:0] SEED_DEFAULT = 16'hACE1;

  // Feedback taps for x^16 + x^14 + x^13 + x^11 + 1 (bit indices of the state)
  localparam int unsigned TAP_0 = 15;
  localparam int unsigned TAP_1 = 13;
  localparam int unsigned TAP_2 = 12;
  localparam int unsigned TAP_3 = 10;

  // The PRNG advances this many steps per accepted transaction. Three state bits are
  // consumed each time, so every mask bit comes from fresh state.
  localparam int unsigned STEPS_PER_TXN = 3;

  // One Fibonacci step: shift left, feedback into bit 0
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    logic fb;
    fb = s[TAP_0] ^ s[TAP_1] ^ s[TAP_2] ^ s[TAP_3];
    return {s[LFSR_W-2:0], fb};
  endfunction

endpackage

// File: rtl/hadd_lfsr3.sv
// PRNG for the masking stage: holds the LFSR state and advances three steps
// per transaction. A reseed has priority over the advance. A zero seed is
// replaced by SEED, so the all-zero lock-up state is never entered.
module hadd_lfsr3
  import hadd_mask_pkg::*;
#(
  parameter int unsigned      LFSR_W = hadd_mask_pkg::LFSR_W,
  parameter logic [15:0]      SEED   = SEED_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_advance,
  input  logic              i_seed_load,
  input  logic [LFSR_W-1:0] i_seed_in,
  output logic [2:0]        o_mask
);

  logic [LFSR_W-1:0] r_state;
  logic [LFSR_W-1:0] w_state_next;
  logic [LFSR_W-1:0] w_chain [0:STEPS_PER_TXN];

  // Unrolled chain of single steps; w_chain[STEPS_PER_TXN] is the post-transaction state
  assign w_chain[0] = r_state;
  genvar gi;
  generate
    for (gi = 0; gi < STEPS_PER_TXN; gi++) begin : g_step
      assign w_chain[gi+1] = lfsr_step(w_chain[gi]);
    end
  endgenerate

  // Next state: reseed wins over the advance and discards it. Otherwise hold.
  always_comb begin
    w_state_next = r_state;
    if (i_seed_load) begin
      w_state_next = (i_seed_in == '0) ? SEED : i_seed_in;
    end else if (i_advance) begin
      w_state_next = w_chain[STEPS_PER_TXN];
    end
  end

  // State register, restored to SEED on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SEED;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Masks come from the current state, before any advance
  assign o_mask = r_state[2:0];

endmodule

// File: rtl/half_adder_share_gen.sv
// Input masking stage for half_adder_masked. Splits the A and B bits into
// Boolean shares using PRNG mask bits, and supplies one fresh r0 per
// transaction. It is a single registered stage with a valid/ready handshake.
// A and B are only ever registered XORed with a mask bit.
module half_adder_share_gen
  import hadd_mask_pkg::*;
#(
  parameter int unsigned LFSR_W = hadd_mask_pkg::LFSR_W,
  parameter logic [15:0] SEED   = SEED_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              A,
  input  logic              B,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              A0,
  output logic              A1,
  output logic              B0,
  output logic              B1,
  output logic              r0
);

  logic       w_accept;
  logic [2:0] w_mask;
  logic       r_out_valid;
  logic       r_a0;
  logic       r_a1;
  logic       r_b0;
  logic       r_b1;
  logic       r_r0;

  // The stage can take new data when it is empty, or when its content leaves this cycle
  assign in_ready = !r_out_valid | out_ready;
  assign w_accept = in_valid & in_ready;

  hadd_lfsr3 #(
    .LFSR_W (LFSR_W),
    .SEED   (SEED)
  ) u_lfsr (
    .clk         (clk),
    .rst         (rst),
    .i_advance   (w_accept),
    .i_seed_load (seed_load),
    .i_seed_in   (seed_in),
    .o_mask      (w_mask)
  );

  // Share registers and the valid flag. The shares keep their values when the stage drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_a0        <= 1'b0;
      r_a1        <= 1'b0;
      r_b0        <= 1'b0;
      r_b1        <= 1'b0;
      r_r0        <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_a0        <= w_mask[0];
      r_a1        <= A ^ w_mask[0];
      r_b0        <= w_mask[1];
      r_b1        <= B ^ w_mask[1];
      r_r0        <= w_mask[2];
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign A0        = r_a0;
  assign A1        = r_a1;
  assign B0        = r_b0;
  assign B1        = r_b1;
  assign r0        = r_r0;

endmodule

// File: tb/tb_half_adder_share_gen.sv
// Directed bench for half_adder_share_gen. It includes a reference PRNG and
// a behavioural masked half adder that consumes the shares.
`timescale 1ns/1ps
module tb_half_adder_share_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        A;
  logic        B;
  logic        seed_load;
  logic [15:0] seed_in;
  logic        out_valid;
  logic        out_ready;
  logic        A0, A1, B0, B1, r0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  half_adder_share_gen dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .A0        (A0),
    .A1        (A1),
    .B0        (B0),
    .B1        (B1),
    .r0        (r0)
  );

  // Reference LFSR step: x^16+x^14+x^13+x^11+1
  function automatic logic [15:0] ref_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [15:0] ref_step3(input logic [15:0] s);
    return ref_step(ref_step(ref_step(s)));
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_shares(input string tag, input logic [4:0] exp);
    chk(tag, {11'd0, A0, A1, B0, B1, r0}, {11'd0, exp});
  endtask

  logic [15:0] m_lfsr;
  logic [4:0]  held;
  logic        ra, rb;
  logic        s0, s1, c0, c1;

  initial begin
    rst = 1'b1; in_valid = 1'b0; A = 1'b0; B = 1'b0;
    seed_load = 1'b0; seed_in = 16'h0000; out_ready = 1'b0;

    // 1: reset state
    #12;
    chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
    chk_shares("rst_shares", 5'b00000);
    @(negedge clk); rst = 1'b0;
    step();
    chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
    chk("rst_lfsr", dut.u_lfsr.r_state, 16'hACE1);
    chk("idle_out_valid", {15'd0, out_valid}, 16'd0);
    $display("[TB] reset checked");
    m_lfsr = 16'hACE1;

    // 2: first transaction A=1,B=1 with SEED masks 1,0,0
    A = 1'b1; B = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    step();
    chk("t2_out_valid", {15'd0, out_valid}, 16'd1);
    chk_shares("t2_shares", 5'b10010);
    m_lfsr = ref_step3(m_lfsr);
    chk("t2_lfsr", dut.u_lfsr.r_state, m_lfsr);
    $display("[TB] txn A=1 B=1 -> %b%b%b%b%b", A0, A1, B0, B1, r0);

    // 3: stall for 5 cycles with new data pending
    out_ready = 1'b0; A = 1'b0; B = 1'b1;
    held = {A0, A1, B0, B1, r0};
    #1;
    chk("t3_in_ready_low", {15'd0, in_ready}, 16'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_hold_valid", {15'd0, out_valid}, 16'd1);
      chk_shares("t3_hold_shares", held);
      chk("t3_hold_ready", {15'd0, in_ready}, 16'd0);
      chk("t3_hold_lfsr", dut.u_lfsr.r_state, m_lfsr);
    end
    out_ready = 1'b1;
    #1;
    chk("t3_in_ready_high", {15'd0, in_ready}, 16'd1);
    step();
    chk("t3_next_valid", {15'd0, out_valid}, 16'd1);
    chk_shares("t3_next_shares", {m_lfsr[0], 1'b0 ^ m_lfsr[0], m_lfsr[1], 1'b1 ^ m_lfsr[1], m_lfsr[2]});
    m_lfsr = ref_step3(m_lfsr);
    held = {A0, A1, B0, B1, r0};
    $display("[TB] txn after stall A=0 B=1 -> %b", held);
    // Drain: out_valid drops, shares hold, PRNG holds
    in_valid = 1'b0;
    step();
    chk("drain_valid", {15'd0, out_valid}, 16'd0);
    chk_shares("drain_shares_hold", held);
    chk("drain_lfsr", dut.u_lfsr.r_state, m_lfsr);

    // 4: reseed with zero -> SEED, then with 7 -> masks all 1
    seed_load = 1'b1; seed_in = 16'h0000;
    step();
    chk("t4_zero_seed", dut.u_lfsr.r_state, 16'hACE1);
    chk_shares("t4_reseed_no_touch", held);
    seed_in = 16'h0007;
    step();
    chk("t4_seed7", dut.u_lfsr.r_state, 16'h0007);
    seed_load = 1'b0; A = 1'b0; B = 1'b0; in_valid = 1'b1;
    step();
    chk_shares("t4_shares", 5'b11111);
    m_lfsr = ref_step3(16'h0007);
    $display("[TB] txn seed=0007 A=0 B=0 -> %b%b%b%b%b", A0, A1, B0, B1, r0);
    // Reseed together with accept: old state masks, seed wins
    seed_load = 1'b1; seed_in = 16'h1234; A = 1'b1; B = 1'b0;
    step();
    chk_shares("t4_seed_accept_shares", {m_lfsr[0], 1'b1 ^ m_lfsr[0], m_lfsr[1], m_lfsr[1], m_lfsr[2]});
    chk("t4_seed_accept_lfsr", dut.u_lfsr.r_state, 16'h1234);
    m_lfsr = 16'h1234;
    seed_load = 1'b0;
    $display("[TB] txn seed+accept -> %b%b%b%b%b", A0, A1, B0, B1, r0);

    // 5: 1000 back-to-back random ops through a masked half adder
    for (int i = 0; i < 1000; i++) begin
      ra = 1'($urandom_range(1)); rb = 1'($urandom_range(1));
      A = ra; B = rb;
      step();
      s0 = A0 ^ B0;
      s1 = A1 ^ B1;
      c0 = (A0 & B0) ^ r0;
      c1 = (A1 & B1) ^ (A0 & B1) ^ (A1 & B0) ^ r0;
      chk("t5_valid", {15'd0, out_valid}, 16'd1);
      chk("t5_masks", {13'd0, r0, B0, A0}, {13'd0, m_lfsr[2:0]});
      chk("t5_a", {15'd0, A0 ^ A1}, {15'd0, ra});
      chk("t5_b", {15'd0, B0 ^ B1}, {15'd0, rb});
      chk("t5_sum", {15'd0, s0 ^ s1}, {15'd0, ra ^ rb});
      chk("t5_carry", {15'd0, c0 ^ c1}, {15'd0, ra & rb});
      m_lfsr = ref_step3(m_lfsr);
      $display("[TB] op %0d A=%b B=%b shares=%b%b%b%b r0=%b", i, ra, rb, A0, A1, B0, B1, r0);
    end

    // 6: reset while stalled with valid output
    in_valid = 1'b0; out_ready = 1'b0;
    step();
    chk("t6_pre_valid", {15'd0, out_valid}, 16'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", {15'd0, out_valid}, 16'd0);
    chk_shares("t6_rst_shares", 5'b00000);
    @(negedge clk); rst = 1'b0;
    step();
    A = 1'b1; B = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    step();
    chk("t6_restart_valid", {15'd0, out_valid}, 16'd1);
    chk_shares("t6_restart_shares", 5'b10010);
    $display("[TB] restart txn A=1 B=1 -> %b%b%b%b%b", A0, A1, B0, B1, r0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
